// File: rtl/gmii_rx_frame_parser.sv
// GMII RX parser: strips preamble/SFD and emits a valid/sop/eop byte stream with length, error status and counters.
// Fixed 2-cycle input-sample-to-rx_data latency; no backpressure, the PHY stream is never stalled.
module gmii_rx_frame_parser #(
  parameter int unsigned MIN_PRE = 1,
  parameter logic [7:0]  SFD_STD = 8'hD5,
  parameter logic [7:0]  SFD_ALT = 8'h5D,
  parameter int unsigned MIN_LEN = 14,
  parameter int unsigned MAX_LEN = 1522
) (
  input  logic        gmii_rxclk,
  input  logic        rst_n,
  input  logic        gmii_rxctrl,
  input  logic [7:0]  gmii_rxdata,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sop,
  output logic        rx_eop,
  output logic        rx_err,
  output logic [15:0] frame_len,
  output logic        sfd_pulse,
  output logic [31:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [3:0]  MIN_PRE_W = 4'(MIN_PRE);
  localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

  logic        rxctrl_q;
  logic [7:0]  rxdata_q;
  state_t      state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        first_q, first_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_sop_q, rx_sop_d;
  logic        rx_eop_q, rx_eop_d;
  logic        rx_err_q, rx_err_d;
  logic [15:0] frame_len_q, frame_len_d;
  logic        sfd_pulse_q, sfd_pulse_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        good_evt, err_evt;
  logic        is_sfd;

  assign is_sfd = (rxdata_q == SFD_STD) || (rxdata_q == SFD_ALT);

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    len_d       = len_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    first_d     = first_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_sop_d    = 1'b0;
    rx_eop_d    = 1'b0;
    rx_err_d    = 1'b0;
    frame_len_d = frame_len_q;
    sfd_pulse_d = 1'b0;
    good_evt    = 1'b0;
    err_evt     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rxctrl_q) begin
          if (rxdata_q == 8'h55) begin
            state_d   = S_PRE;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = S_DROP;
            err_evt = 1'b1;
          end
        end
      end

      S_PRE: begin
        if (!rxctrl_q) begin
          state_d = S_IDLE;
          err_evt = 1'b1;
        end else if (rxdata_q == 8'h55) begin
          if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if (is_sfd && (pre_cnt_q >= MIN_PRE_W)) begin
          state_d     = S_DATA;
          sfd_pulse_d = 1'b1;
          len_d       = 16'd0;
          first_d     = 1'b1;
          hold_vld_d  = 1'b0;
        end else begin
          state_d = S_DROP;
          err_evt = 1'b1;
        end
      end

      S_DATA: begin
        if (rxctrl_q) begin
          if (len_q == MAX_LEN_W) begin
            // A byte beyond the legal maximum: close the frame on the held byte and discard the rest.
            rx_data_d   = hold_q;
            rx_valid_d  = 1'b1;
            rx_sop_d    = first_q;
            rx_eop_d    = 1'b1;
            rx_err_d    = 1'b1;
            frame_len_d = MAX_LEN_W;
            err_evt     = 1'b1;
            hold_vld_d  = 1'b0;
            first_d     = 1'b0;
            state_d     = S_DROP;
          end else begin
            hold_d     = rxdata_q;
            hold_vld_d = 1'b1;
            len_d      = len_q + 16'd1;
            if (hold_vld_q) begin
              rx_data_d  = hold_q;
              rx_valid_d = 1'b1;
              rx_sop_d   = first_q;
              first_d    = 1'b0;
            end
          end
        end else begin
          if (hold_vld_q) begin
            rx_data_d   = hold_q;
            rx_valid_d  = 1'b1;
            rx_sop_d    = first_q;
            rx_eop_d    = 1'b1;
            rx_err_d    = (len_q < MIN_LEN_W);
            frame_len_d = len_q;
            good_evt    = (len_q >= MIN_LEN_W);
            err_evt     = (len_q < MIN_LEN_W);
          end else begin
            err_evt = 1'b1;
          end
          hold_vld_d = 1'b0;
          first_d    = 1'b0;
          state_d    = S_IDLE;
        end
      end

      S_DROP: begin
        if (!rxctrl_q) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    frame_cnt_d = (good_evt && (frame_cnt_q != '1)) ? frame_cnt_q + 32'd1 : frame_cnt_q;
    err_cnt_d   = (err_evt && (err_cnt_q != '1)) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  always_ff @(posedge gmii_rxclk or negedge rst_n) begin
    if (!rst_n) begin
      rxctrl_q    <= 1'b0;
      rxdata_q    <= 8'h00;
      state_q     <= S_IDLE;
      pre_cnt_q   <= 4'd0;
      len_q       <= 16'd0;
      hold_q      <= 8'h00;
      hold_vld_q  <= 1'b0;
      first_q     <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_sop_q    <= 1'b0;
      rx_eop_q    <= 1'b0;
      rx_err_q    <= 1'b0;
      frame_len_q <= 16'd0;
      sfd_pulse_q <= 1'b0;
      frame_cnt_q <= 32'd0;
      err_cnt_q   <= 16'd0;
    end else begin
      rxctrl_q    <= gmii_rxctrl;
      rxdata_q    <= gmii_rxdata;
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      len_q       <= len_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      first_q     <= first_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_sop_q    <= rx_sop_d;
      rx_eop_q    <= rx_eop_d;
      rx_err_q    <= rx_err_d;
      frame_len_q <= frame_len_d;
      sfd_pulse_q <= sfd_pulse_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_sop    = rx_sop_q;
  assign rx_eop    = rx_eop_q;
  assign rx_err    = rx_err_q;
  assign frame_len = frame_len_q;
  assign sfd_pulse = sfd_pulse_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gmii_rx_frame_parser.sv
// Directed bench for gmii_rx_frame_parser: drives GMII bytes on the falling edge, records output beats on the falling edge.
module tb_gmii_rx_frame_parser;

  logic        clk;
  logic        rst_n;
  logic        gmii_rxctrl;
  logic [7:0]  gmii_rxdata;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sop;
  logic        rx_eop;
  logic        rx_err;
  logic [15:0] frame_len;
  logic        sfd_pulse;
  logic [31:0] frame_cnt;
  logic [15:0] err_cnt;

  gmii_rx_frame_parser dut (
    .gmii_rxclk (clk),
    .rst_n      (rst_n),
    .gmii_rxctrl(gmii_rxctrl),
    .gmii_rxdata(gmii_rxdata),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_sop     (rx_sop),
    .rx_eop     (rx_eop),
    .rx_err     (rx_err),
    .frame_len  (frame_len),
    .sfd_pulse  (sfd_pulse),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic        sop;
    logic        eop;
    logic        err;
    logic [15:0] len;
    int          cyc;
  } beat_t;

  int    cyc = 0;
  beat_t bq[$];
  int    sfd_n = 0;
  int    sfd_cyc = 0;
  int    checks = 0;
  int    errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      beat_t b;
      b.d = rx_data; b.sop = rx_sop; b.eop = rx_eop; b.err = rx_err;
      b.len = frame_len; b.cyc = cyc;
      bq.push_back(b);
    end
    if (sfd_pulse) begin
      sfd_n   = sfd_n + 1;
      sfd_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic c, input logic [7:0] d);
    @(negedge clk);
    gmii_rxctrl = c;
    gmii_rxdata = d;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  task automatic preamble(input int n, input logic [7:0] sfd);
    for (int i = 0; i < n; i++) drive(1'b1, 8'h55);
    drive(1'b1, sfd);
  endtask

  initial begin
    int b0, s0, t0, bad;
    rst_n       = 1'b0;
    gmii_rxctrl = 1'b0;
    gmii_rxdata = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_frame_len", 32'(frame_len), 0);
    chk("rst_sfd", 32'(sfd_pulse), 0);
    @(negedge clk);
    rst_n = 1'b1;
    gap(3);

    // Test 1: 60-byte frame with alternate SFD
    b0 = bq.size(); s0 = sfd_n; t0 = 0;
    preamble(3, 8'h5D);
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, 8'(i));
      if (i == 0) t0 = cyc + 1;
    end
    gap(6);
    chk("t1_beats", 32'(bq.size() - b0), 60);
    bad = 0;
    for (int i = 0; i < 60; i++) if (bq[b0 + i].d !== 8'(i)) bad++;
    chk("t1_data_seq", 32'(bad), 0);
    chk("t1_sop_first", 32'(bq[b0].sop), 1);
    chk("t1_eop_first", 32'(bq[b0].eop), 0);
    chk("t1_eop_last", 32'(bq[b0 + 59].eop), 1);
    chk("t1_sop_last", 32'(bq[b0 + 59].sop), 0);
    chk("t1_err", 32'(bq[b0 + 59].err), 0);
    chk("t1_len", 32'(bq[b0 + 59].len), 60);
    chk("t1_first_lat", 32'(bq[b0].cyc), 32'(t0 + 2));
    chk("t1_last_lat", 32'(bq[b0 + 59].cyc), 32'(t0 + 61));
    chk("t1_sfd_n", 32'(sfd_n - s0), 1);
    chk("t1_sfd_cyc", 32'(sfd_cyc), 32'(t0));
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_err_cnt", 32'(err_cnt), 0);

    // Test 2: two minimum-length frames separated by one idle cycle
    b0 = bq.size();
    preamble(7, 8'hD5);
    for (int i = 0; i < 14; i++) drive(1'b1, 8'hA0 + 8'(i));
    gap(1);
    preamble(7, 8'hD5);
    for (int i = 0; i < 14; i++) drive(1'b1, 8'hA0 + 8'(i));
    gap(6);
    chk("t2_beats", 32'(bq.size() - b0), 28);
    chk("t2_eop1", 32'(bq[b0 + 13].eop), 1);
    chk("t2_len1", 32'(bq[b0 + 13].len), 14);
    chk("t2_err1", 32'(bq[b0 + 13].err), 0);
    chk("t2_sop2", 32'(bq[b0 + 14].sop), 1);
    chk("t2_dat2", 32'(bq[b0 + 14].d), 32'hA0);
    chk("t2_len2", 32'(bq[b0 + 27].len), 14);
    chk("t2_err2", 32'(bq[b0 + 27].err), 0);
    chk("t2_frame_cnt", frame_cnt, 3);

    // Test 3: runt frame of 5 bytes
    b0 = bq.size();
    preamble(1, 8'hD5);
    for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i));
    gap(6);
    chk("t3_beats", 32'(bq.size() - b0), 5);
    chk("t3_eop", 32'(bq[b0 + 4].eop), 1);
    chk("t3_eop_dat", 32'(bq[b0 + 4].d), 5);
    chk("t3_len", 32'(bq[b0 + 4].len), 5);
    chk("t3_err", 32'(bq[b0 + 4].err), 1);
    chk("t3_err_cnt", 32'(err_cnt), 1);
    chk("t3_frame_cnt", frame_cnt, 3);

    // Test 4: oversize frame, truncated at 1522 bytes
    b0 = bq.size();
    preamble(1, 8'hD5);
    for (int i = 0; i < 1600; i++) drive(1'b1, 8'(i));
    gap(6);
    chk("t4_beats", 32'(bq.size() - b0), 1522);
    chk("t4_eop", 32'(bq[b0 + 1521].eop), 1);
    chk("t4_eop_dat", 32'(bq[b0 + 1521].d), 32'hF1);
    chk("t4_err", 32'(bq[b0 + 1521].err), 1);
    chk("t4_len", 32'(bq[b0 + 1521].len), 1522);
    chk("t4_err_cnt", 32'(err_cnt), 2);
    chk("t4_frame_cnt", frame_cnt, 3);

    // Test 5: bad preamble, then a burst with no preamble at all
    b0 = bq.size(); s0 = sfd_n;
    drive(1'b1, 8'h55); drive(1'b1, 8'hAA); drive(1'b1, 8'hBB);
    gap(2);
    drive(1'b1, 8'h12); drive(1'b1, 8'h34); drive(1'b1, 8'h56);
    gap(6);
    chk("t5_beats", 32'(bq.size() - b0), 0);
    chk("t5_sfd_n", 32'(sfd_n - s0), 0);
    chk("t5_err_cnt", 32'(err_cnt), 4);
    chk("t5_len_held", 32'(frame_len), 1522);

    // Test 6: reset asserted mid-frame, released later in the same frame
    b0 = bq.size();
    preamble(1, 8'hD5);
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 8'(i));
      if (i == 30) begin
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(rx_valid), 0);
        chk("t6_rst_frame_cnt", frame_cnt, 0);
        chk("t6_rst_err_cnt", 32'(err_cnt), 0);
        chk("t6_rst_len", 32'(frame_len), 0);
      end
      if (i == 40) rst_n = 1'b1;
    end
    gap(6);
    chk("t6_beats", 32'(bq.size() - b0), 28);
    bad = 0;
    for (int i = b0; i < bq.size(); i++) if (bq[i].eop) bad++;
    chk("t6_no_eop", 32'(bad), 0);
    chk("t6_err_cnt", 32'(err_cnt), 1);

    b0 = bq.size();
    preamble(2, 8'hD5);
    for (int i = 0; i < 20; i++) drive(1'b1, 8'h30 + 8'(i));
    gap(6);
    chk("t6b_beats", 32'(bq.size() - b0), 20);
    chk("t6b_sop", 32'(bq[b0].sop), 1);
    chk("t6b_dat", 32'(bq[b0].d), 32'h30);
    chk("t6b_eop", 32'(bq[b0 + 19].eop), 1);
    chk("t6b_err", 32'(bq[b0 + 19].err), 0);
    chk("t6b_len", 32'(frame_len), 20);
    chk("t6b_frame_cnt", frame_cnt, 1);
    chk("t6b_err_cnt", 32'(err_cnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
